turn_lever_conditioner: RTL and testbench

//  Front-end for the turn-signal lamp FSM. Takes raw, bouncy cockpit switches
//  (left lever, right lever, hazard push-button) and produces clean, mutually

---
 rtl/turn_sig_pkg.sv | 7 +
 rtl/debounce_filter.sv | 28 ++
 rtl/turn_lever_conditioner.sv | 40 ++++
 tb/tb_turn_lever_conditioner.sv | 93 +++++++++
 4 files changed

// File: rtl/turn_sig_pkg.sv
// turn_sig_pkg: lever conditioner state encoding and Moore output decode.
package turn_sig_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} lever_state_t;
  function automatic logic [2:0] lever_outs(lever_state_t s);
    return {s == LEFT || s == HAZARD, s == RIGHT || s == HAZARD, s == HAZARD};
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: two-flop synchronizer followed by a consecutive-cycle debounce counter.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  logic sync1, sync2;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/turn_lever_conditioner.sv
// turn_lever_conditioner: debounces cockpit switches and produces consistent left/right/hazard requests.
module turn_lever_conditioner
  import turn_sig_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lever_l_raw,
  input  logic lever_r_raw,
  input  logic hazard_btn_raw,
  output logic left,
  output logic right,
  output logic hazard_active
);
  logic db_l, db_r, db_h, prev_h, hazard_edge;
  lever_state_t state, next;
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (.clk(clk), .reset(reset), .raw(lever_l_raw), .db(db_l));
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clk(clk), .reset(reset), .raw(lever_r_raw), .db(db_r));
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_h (.clk(clk), .reset(reset), .raw(hazard_btn_raw), .db(db_h));
  assign hazard_edge = db_h & ~prev_h;
  // Hazard edge takes priority; LEFT/RIGHT always fall back to IDLE before swapping sides.
  always_comb begin
    next = state;
    if (hazard_edge) next = (state == HAZARD) ? IDLE : HAZARD;
    else if (state == IDLE) next = (db_l & ~db_r) ? LEFT : (db_r & ~db_l) ? RIGHT : IDLE;
    else if (state == LEFT) next = (!db_l || db_r) ? IDLE : LEFT;
    else if (state == RIGHT) next = (!db_r || db_l) ? IDLE : RIGHT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      prev_h <= 1'b0;
      {left, right, hazard_active} <= 3'b000;
    end else begin
      state  <= next;
      prev_h <= db_h;
      {left, right, hazard_active} <= lever_outs(next);
    end
endmodule

// File: tb/tb_turn_lever_conditioner.sv
// tb_turn_lever_conditioner: directed vectors with hand-computed expected {left,right,hazard_active}.
module tb_turn_lever_conditioner;
  logic clk = 1'b0;
  logic reset, lever_l_raw, lever_r_raw, hazard_btn_raw;
  logic left, right, hazard_active;
  logic [2:0] outs;
  logic [15:0] pat;
  int total = 0;
  int passed = 0;
  turn_lever_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .lever_l_raw(lever_l_raw), .lever_r_raw(lever_r_raw),
    .hazard_btn_raw(hazard_btn_raw), .left(left), .right(right), .hazard_active(hazard_active)
  );
  assign outs = {left, right, hazard_active};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got lrh=%b expected lrh=%b at %0t", tag, obs, exp, $time);
    else passed++;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    reset = 1'b1;
    lever_l_raw = 1'b0;
    lever_r_raw = 1'b0;
    hazard_btn_raw = 1'b0;
    @(negedge clk); check("rst_a", outs, 3'b000);
    @(negedge clk); check("rst_b", outs, 3'b000);
    #2 reset = 1'b0;
    @(negedge clk); check("rst_rel", outs, 3'b000);
    tick(1);
    lever_l_raw = 1'b1;
    tick(6); @(negedge clk); check("l_pre", outs, 3'b000);
    tick(1); @(negedge clk); check("l_on", outs, 3'b100);
    tick(1);
    lever_l_raw = 1'b0;
    tick(6); @(negedge clk); check("l_off_pre", outs, 3'b100);
    tick(1); @(negedge clk); check("l_off", outs, 3'b000);
    tick(1);
    pat = 16'b1100_1010_0000_0000;
    for (int i = 0; i < 16; i++) begin
      lever_r_raw = pat[15-i];
      @(negedge clk); check("r_glitch", outs, 3'b000);
      tick(1);
    end
    lever_r_raw = 1'b0;
    hazard_btn_raw = 1'b1;
    lever_l_raw = 1'b1;
    tick(6); @(negedge clk); check("hz_pre", outs, 3'b000);
    tick(1); @(negedge clk); check("hz_on", outs, 3'b111);
    tick(3);
    hazard_btn_raw = 1'b0;
    tick(10); @(negedge clk); check("hz_hold", outs, 3'b111);
    tick(1);
    hazard_btn_raw = 1'b1;
    tick(6); @(negedge clk); check("hz_exit_pre", outs, 3'b111);
    tick(1); @(negedge clk); check("hz_idle", outs, 3'b000);
    tick(1); @(negedge clk); check("hz_to_left", outs, 3'b100);
    tick(1);
    hazard_btn_raw = 1'b0;
    tick(8); @(negedge clk); check("hz_rel_left", outs, 3'b100);
    tick(1);
    lever_r_raw = 1'b1;
    tick(6); @(negedge clk); check("both_pre", outs, 3'b100);
    tick(1); @(negedge clk); check("both_idle", outs, 3'b000);
    tick(5); @(negedge clk); check("both_hold", outs, 3'b000);
    tick(1);
    lever_l_raw = 1'b0;
    tick(6); @(negedge clk); check("swap_gap", outs, 3'b000);
    tick(1); @(negedge clk); check("swap_right", outs, 3'b010);
    tick(1);
    lever_r_raw = 1'b0;
    tick(7); @(negedge clk); check("r_rel", outs, 3'b000);
    tick(1);
    hazard_btn_raw = 1'b1;
    tick(7); @(negedge clk); check("hz2_on", outs, 3'b111);
    #2 reset = 1'b1;
    lever_l_raw = 1'b1;
    hazard_btn_raw = 1'b0;
    #1 check("async_rst", outs, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(6); @(negedge clk); check("redb_pre", outs, 3'b000);
    tick(1); @(negedge clk); check("redb_on", outs, 3'b100);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
